// File: rtl/vending_pkg.sv
// Shared types for the coin front-end and the VendingMachine: coin codes,
// debounce-detector states and raw sensor patterns.
package vending_pkg;

  typedef enum logic [1:0] {COIN_NONE, COIN_FIVE, COIN_TEN, COIN_BAD} coin_e;
  typedef enum logic [1:0] {D_IDLE, D_QUAL, D_HOLD, D_RELQ} det_state_e;

  localparam logic [1:0] PAT_FIVE = 2'b01;
  localparam logic [1:0] PAT_TEN  = 2'b10;

  function automatic coin_e classify(input logic [1:0] pat);
    case (pat)
      PAT_FIVE: return COIN_FIVE;
      PAT_TEN:  return COIN_TEN;
      2'b11:    return COIN_BAD;
      default:  return COIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small coin queue with a 1-bit payload (0 = five, 1 = ten). A push while full
// is only taken when a pop frees a slot in the same cycle.
module coin_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronise and debounce both sensors, classify each
// insertion, queue valid coins and release them as spaced one-cycle pulses.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sense_five_raw,
  input  logic                    sense_ten_raw,
  input  logic                    accept_en,
  output logic                    five_rup,
  output logic                    ten_rup,
  output logic                    coin_reject,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    fifo_full
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  logic [1:0]    r_sync_p0, r_sync_p1;
  logic [1:0]    w_s;
  det_state_e    r_state, w_state_nxt;
  logic [1:0]    r_pat, w_pat_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  coin_e         w_evt, r_evt;
  logic          w_push, w_pop, w_din, w_dout, w_full, w_empty;
  logic          r_five, r_ten, r_reject;
  logic [GW-1:0] r_gap;

  // Stage p0/p1: two-flop synchroniser, s = {ten, five}
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= {sense_ten_raw, sense_five_raw};
      r_sync_p1 <= r_sync_p0;
    end
  end
  assign w_s = r_sync_p1;

  // Stage detect: debounce FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= D_IDLE;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      D_IDLE: if (w_s != 2'b00) begin
        w_state_nxt = D_QUAL;
        w_pat_nxt   = w_s;
        w_cnt_nxt   = CW'(1);
      end
      D_QUAL: if (w_s == r_pat) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == DEB_LAST) w_state_nxt = D_HOLD;
      end else begin
        w_state_nxt = D_IDLE;
      end
      D_HOLD: if (w_s == 2'b00) begin
        w_state_nxt = D_RELQ;
        w_cnt_nxt   = CW'(1);
      end
      D_RELQ: if (w_s == 2'b00) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == DEB_LAST) w_state_nxt = D_IDLE;
      end else begin
        w_state_nxt = D_HOLD;
      end
      default: w_state_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    w_evt = COIN_NONE;
    if (r_state == D_QUAL && w_s == r_pat && r_cnt == DEB_LAST) w_evt = classify(r_pat);
  end

  // Stage queue: registered event feeds the FIFO one cycle later
  always_ff @(posedge clk) begin
    if (rst) r_evt <= COIN_NONE;
    else     r_evt <= w_evt;
  end

  assign w_push = (r_evt == COIN_FIVE) || (r_evt == COIN_TEN);
  assign w_din  = (r_evt == COIN_TEN);
  assign w_pop  = !w_empty && accept_en && (r_gap == '0);

  coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Stage out: pulse registers and inter-pulse gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_five   <= 1'b0;
      r_ten    <= 1'b0;
      r_reject <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_five   <= w_pop && !w_dout;
      r_ten    <= w_pop && w_dout;
      r_reject <= (r_evt == COIN_BAD) || (w_push && w_full && !w_pop);
      if (w_pop)             r_gap <= GAP_LOAD;
      else if (r_gap != '0)  r_gap <= r_gap - 1'b1;
    end
  end

  // Masked by rst so a pulse never overlaps a reset cycle.
  assign five_rup    = r_five && !rst;
  assign ten_rup     = r_ten && !rst;
  assign coin_reject = r_reject && !rst;
  assign fifo_full   = w_full;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: table of single insertions plus
// hand-written latency, bounce, FIFO-full and reset sequences.
module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sense_five_raw = 1'b0;
  logic       sense_ten_raw  = 1'b0;
  logic       accept_en      = 1'b1;
  logic       five_rup, ten_rup, coin_reject, fifo_full;
  logic [2:0] fifo_count;

  coin_acceptor dut (
    .clk            (clk),
    .rst            (rst),
    .sense_five_raw (sense_five_raw),
    .sense_ten_raw  (sense_ten_raw),
    .accept_en      (accept_en),
    .five_rup       (five_rup),
    .ten_rup        (ten_rup),
    .coin_reject    (coin_reject),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_five = 0, n_ten = 0, n_rej = 0, n_both = 0;
  int seq[$];
  int pcyc[$];

  initial begin
    forever begin
      @(negedge clk);
      if (five_rup)    begin n_five++; seq.push_back(0); pcyc.push_back(cyc); end
      if (ten_rup)     begin n_ten++;  seq.push_back(1); pcyc.push_back(cyc); end
      if (coin_reject) n_rej++;
      if (five_rup && ten_rup) n_both++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_five = 0; n_ten = 0; n_rej = 0; n_both = 0;
    seq.delete();
    pcyc.delete();
  endtask

  task automatic insert(input logic f, input logic t, input int hold, input int rel);
    sense_five_raw = f;
    sense_ten_raw  = t;
    tick(hold);
    sense_five_raw = 1'b0;
    sense_ten_raw  = 1'b0;
    tick(rel);
  endtask

  typedef struct {
    string name;
    logic  five;
    logic  ten;
    int    hold;
    int    exp_five;
    int    exp_ten;
    int    exp_rej;
  } vec_t;

  vec_t vecs[6];
  int   t0;

  initial begin
    vecs[0] = '{"five_10",  1'b1, 1'b0, 10, 1, 0, 0};
    vecs[1] = '{"ten_10",   1'b0, 1'b1, 10, 0, 1, 0};
    vecs[2] = '{"five_3",   1'b1, 1'b0,  3, 0, 0, 0};
    vecs[3] = '{"both_10",  1'b1, 1'b1, 10, 0, 0, 1};
    vecs[4] = '{"ten_4",    1'b0, 1'b1,  4, 0, 1, 0};
    vecs[5] = '{"five_1",   1'b1, 1'b0,  1, 0, 0, 0};

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_five", int'(five_rup), 0);
    check("rst_ten", int'(ten_rup), 0);
    check("rst_reject", int'(coin_reject), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_full", int'(fifo_full), 0);
    tick(2);

    // Latency: pulse 7 edges after the first edge that samples raw high
    clear_mon();
    t0 = cyc + 1;
    insert(1'b1, 1'b0, 10, 20);
    check("lat_n_five", n_five, 1);
    check("lat_cycle", (pcyc.size() > 0) ? pcyc[0] - t0 : -1, 7);
    check("lat_n_ten", n_ten, 0);
    check("lat_rej", n_rej, 0);

    // Table of single insertions
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      insert(vecs[i].five, vecs[i].ten, vecs[i].hold, 20);
      check({vecs[i].name, "_five"}, n_five, vecs[i].exp_five);
      check({vecs[i].name, "_ten"},  n_ten,  vecs[i].exp_ten);
      check({vecs[i].name, "_rej"},  n_rej,  vecs[i].exp_rej);
      check({vecs[i].name, "_cnt"},  int'(fifo_count), 0);
    end

    // Bouncy ten sensor, then stable
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      sense_ten_raw = (i % 2 == 0);
      tick(2);
    end
    insert(1'b0, 1'b1, 10, 20);
    check("bounce_ten", n_ten, 1);
    check("bounce_five", n_five, 0);
    check("bounce_rej", n_rej, 0);

    // Fill FIFO with accept_en low, overflow rejects
    clear_mon();
    accept_en = 1'b0;
    insert(1'b1, 1'b0, 6, 12);
    insert(1'b0, 1'b1, 6, 12);
    insert(1'b1, 1'b0, 6, 12);
    insert(1'b0, 1'b1, 6, 12);
    check("fill_count", int'(fifo_count), 4);
    check("fill_full", int'(fifo_full), 1);
    check("fill_rej_before", n_rej, 0);
    insert(1'b1, 1'b0, 6, 12);
    check("overflow_rej", n_rej, 1);
    check("overflow_count", int'(fifo_count), 4);
    check("held_pulses", n_five + n_ten, 0);
    clear_mon();
    accept_en = 1'b1;
    tick(30);
    check("drain_n", seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_order%0d", i), (seq.size() > i) ? seq[i] : -1, i % 2);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_gap%0d", i), (pcyc.size() > i + 1) ? pcyc[i+1] - pcyc[i] : -1, 4);
    end
    check("drain_count", int'(fifo_count), 0);
    check("drain_full", int'(fifo_full), 0);

    // Reset discards queued coins
    clear_mon();
    accept_en = 1'b0;
    insert(1'b1, 1'b0, 6, 12);
    insert(1'b0, 1'b1, 6, 12);
    check("queued2", int'(fifo_count), 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    accept_en = 1'b1;
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_five", int'(five_rup), 0);
    check("mid_rst_ten", int'(ten_rup), 0);
    check("mid_rst_rej", int'(coin_reject), 0);
    tick(20);
    check("post_rst_pulses", n_five + n_ten, 0);
    check("post_rst_count", int'(fifo_count), 0);

    check("never_both", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
